// File: rtl/timed_stream_ctrl.sv
// Timed ADC/DAC stream sequencer: sample-index counter, armed start, run length, fault holdoff.
// Optional TIMED_STREAM_PPS_LOAD_EN: idx_load is deferred to the next pps rising edge.
module timed_stream_ctrl #(
    parameter int unsigned IDX_WIDTH  = 64,
    parameter int unsigned LEN_WIDTH  = 32,
    parameter int unsigned WAIT_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic                  sample_tick,
    input  logic                  idx_load,
    input  logic [IDX_WIDTH-1:0]  idx_load_value,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic [IDX_WIDTH-1:0]  start_idx,
    input  logic [LEN_WIDTH-1:0]  run_len,
    input  logic [WAIT_WIDTH-1:0] overflow_wait,
    input  logic                  adc_overflow,
    input  logic                  dac_underflow,
`ifdef TIMED_STREAM_PPS_LOAD_EN
    input  logic                  pps,
    output logic                  load_pending,
`endif
    output logic [IDX_WIDTH-1:0]  sample_idx,
    output logic                  stream_en,
    output logic [1:0]            state,
    output logic                  late_start,
    output logic [CNT_WIDTH-1:0]  fault_count,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RUN     = 2'd2,
        S_RECOVER = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [IDX_WIDTH-1:0]  start_q, start_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  run_cnt_q, run_cnt_d;
    logic [LEN_WIDTH-1:0]  run_cnt_inc;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic [CNT_WIDTH-1:0]  fcnt_q, fcnt_d;
    logic                  late_q, late_d;
    logic                  en_q, en_d;
    logic                  done_q, done_d;
    logic                  fault;

`ifdef TIMED_STREAM_PPS_LOAD_EN
    logic pps_q;
    logic pend_q, pend_d;

    // A load request waits for the next pps rising edge; a request on that same edge applies at once.
    always_comb begin
        idx_d  = idx_q;
        pend_d = pend_q | idx_load;
        if (pps && !pps_q && (pend_q || idx_load)) begin
            idx_d  = idx_load_value;
            pend_d = 1'b0;
        end else if (sample_tick) begin
            idx_d = idx_q + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            pps_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            pps_q  <= pps;
            pend_q <= pend_d;
        end
    end

    assign load_pending = pend_q;
`else
    always_comb begin
        idx_d = idx_q;
        if (idx_load) begin
            idx_d = idx_load_value;
        end else if (sample_tick) begin
            idx_d = idx_q + IDX_WIDTH'(1);
        end
    end
`endif

    assign fault       = adc_overflow | dac_underflow;
    assign run_cnt_inc = run_cnt_q + LEN_WIDTH'(1);

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            start_q   <= '0;
            len_q     <= '0;
            run_cnt_q <= '0;
            wait_q    <= '0;
            fcnt_q    <= '0;
            late_q    <= 1'b0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            start_q   <= start_d;
            len_q     <= len_d;
            run_cnt_q <= run_cnt_d;
            wait_q    <= wait_d;
            fcnt_q    <= fcnt_d;
            late_q    <= late_d;
            en_q      <= en_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        len_d     = len_q;
        run_cnt_d = run_cnt_q;
        wait_d    = wait_q;
        fcnt_d    = fcnt_q;
        late_d    = late_q;
        done_d    = 1'b0;
        if (disarm) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        start_d = start_idx;
                        len_d   = run_len;
                        late_d  = 1'b0;
                        fcnt_d  = '0;
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (idx_q >= start_q) begin
                        state_d   = S_RUN;
                        run_cnt_d = '0;
                        late_d    = late_q | (idx_q != start_q);
                    end
                end
                S_RUN: begin
                    if (sample_tick) begin
                        run_cnt_d = run_cnt_inc;
                    end
                    // Completion outranks a simultaneous fault.
                    if (sample_tick && (len_q != '0) && (run_cnt_inc == len_q)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (fault) begin
                        state_d = S_RECOVER;
                        wait_d  = overflow_wait;
                        if (fcnt_q != '1) begin
                            fcnt_d = fcnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                S_RECOVER: begin
                    // A persisting fault keeps restarting the holdoff, so the stream stays gated.
                    if (fault) begin
                        wait_d = overflow_wait;
                    end else if (wait_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        wait_d = wait_q - WAIT_WIDTH'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        en_d = (state_d == S_RUN);
    end

    assign sample_idx  = idx_q;
    assign stream_en   = en_q;
    assign state       = state_q;
    assign late_start  = late_q;
    assign fault_count = fcnt_q;
    assign done        = done_q;

endmodule
